sm3_expnd: RTL



---
 rtl/sm3_expnd.sv | 135 +++++++++++++
 1 files changed

// File: rtl/sm3_expnd.sv
// SM3 message expansion: loads one 16-word padded block, then streams
// the (Wj, W'j) pairs for j = 0..63 to the compression stage.
module sm3_expnd #(
    parameter int WORD_DW = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WORD_DW-1:0] pad_otpt_d_i,
    input  logic               pad_otpt_vld_i,
    input  logic               pad_otpt_lst_i,
    output logic               pad_otpt_ena_o,
    output logic [WORD_DW-1:0] expnd_otpt_wj_o,
    output logic [WORD_DW-1:0] expnd_otpt_wjj_o,
    output logic [5:0]         expnd_otpt_j_o,
    output logic               expnd_otpt_vld_o,
    output logic               expnd_otpt_lst_o,
    input  logic               expnd_otpt_rdy_i
);

    if (WORD_DW != 32) begin : g_dw_chk
        $error("sm3_expnd: WORD_DW must be 32");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_EXPND
    } state_t;

    state_t             state_q, state_d;
    logic [WORD_DW-1:0] win_q [16];
    logic [WORD_DW-1:0] win_d [16];
    logic [5:0]         rcnt_q, rcnt_d;
    logic               lst_flg_q, lst_flg_d;
    logic               ena_q, ena_d;
    logic               vld_q, vld_d;
    logic               ld_xfer;
    logic               ex_xfer;
    logic [WORD_DW-1:0] p1_in;
    logic [WORD_DW-1:0] w_new;

    function automatic logic [WORD_DW-1:0] rol(
        input logic [WORD_DW-1:0] x,
        input int unsigned        n
    );
        return (x << n) | (x >> (WORD_DW - n));
    endfunction

    function automatic logic [WORD_DW-1:0] p1(
        input logic [WORD_DW-1:0] x
    );
        return x ^ rol(x, 15) ^ rol(x, 23);
    endfunction

    assign ld_xfer = pad_otpt_vld_i && ena_q;
    assign ex_xfer = vld_q && expnd_otpt_rdy_i;

    // win[k] holds W(j+k), so this is W(j+16) in standard SM3 terms
    assign p1_in = win_q[0] ^ win_q[7] ^ rol(win_q[13], 15);
    assign w_new = p1(p1_in) ^ rol(win_q[3], 7) ^ win_q[10];

    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        rcnt_d    = rcnt_q;
        lst_flg_d = lst_flg_q;
        unique case (state_q)
            S_IDLE: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                if (ld_xfer) begin
                    win_d[rcnt_q[3:0]] = pad_otpt_d_i;
                    if (rcnt_q == 6'd15) begin
                        lst_flg_d = pad_otpt_lst_i;
                        rcnt_d    = 6'd0;
                        state_d   = S_EXPND;
                    end else begin
                        rcnt_d = rcnt_q + 6'd1;
                    end
                end
            end
            S_EXPND: begin
                if (ex_xfer) begin
                    for (int k = 0; k < 15; k++) begin
                        win_d[k] = win_q[k+1];
                    end
                    win_d[15] = w_new;
                    if (rcnt_q == 6'd63) begin
                        rcnt_d    = 6'd0;
                        lst_flg_d = 1'b0;
                        state_d   = S_LOAD;
                    end else begin
                        rcnt_d = rcnt_q + 6'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        ena_d = (state_d == S_LOAD);
        vld_d = (state_d == S_EXPND);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            rcnt_q    <= 6'd0;
            lst_flg_q <= 1'b0;
            ena_q     <= 1'b0;
            vld_q     <= 1'b0;
            for (int k = 0; k < 16; k++) begin
                win_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            rcnt_q    <= rcnt_d;
            lst_flg_q <= lst_flg_d;
            ena_q     <= ena_d;
            vld_q     <= vld_d;
            for (int k = 0; k < 16; k++) begin
                win_q[k] <= win_d[k];
            end
        end
    end

    assign pad_otpt_ena_o   = ena_q;
    assign expnd_otpt_vld_o = vld_q;
    assign expnd_otpt_wj_o  = win_q[0];
    assign expnd_otpt_wjj_o = win_q[0] ^ win_q[4];
    assign expnd_otpt_j_o   = rcnt_q;
    assign expnd_otpt_lst_o = lst_flg_q && (rcnt_q == 6'd63);

endmodule
